rv64_decode_stage: RTL and testbench
====================================

// Module: rv64_decode_stage
// PURPOSE
//  Pipelined RV64IM decode stage. It sits between instruction fetch and the execute ALU.
//  - Accepts 32-bit instruction words with their PC over a valid/ready handshake.
//  - Emits the 8-bit ALU op code, register indices, immediate, shamt and PC consumed by the ALU.
//  - Registered output plus a 1-entry skid buffer, so in_ready never depends combinationally on out_ready.
// PARAMETERS
//  XLEN          64     datapath width of imm/shamt/pc outputs
//  ILLEGAL_OP    8'hFF  op code emitted for undecodable words
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     asynchronous active-low reset
//  flush         in   1     drop all held/in-flight instructions (branch redirect)
//  in_valid      in   1     fetch word valid
//  in_ready      out  1     stage can accept a word this cycle
//  in_inst       in   32    raw instruction word
//  in_pc         in   XLEN  PC of in_inst
//  out_valid     out  1     decoded bundle valid
//  out_ready     in   1     execute accepts bundle
//  out_op        out  8     ALU op code (shared package encoding)
//  out_rd        out  5     destination register index
//  out_rs1       out  5     source 1 index
//  out_rs2       out  5     source 2 index
//  out_imm       out  XLEN  sign-extended immediate (format rules below)
//  out_shamt     out  XLEN  zero-extended inst[25:20]; W-forms use inst[24:20]
//  out_pc        out  XLEN  PC of decoded instruction
//  out_rd_we     out  1     instruction writes rd (0 for S/B/ECALL/EBREAK/illegal, or when rd==0)
//  out_illegal   out  1     word not in the supported set
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, skid empty. out_op=ILLEGAL_OP, all other outputs 0.
//  - Transfers: an input transfer is in_valid&in_ready; an output transfer is out_valid&out_ready.
//  - Latency: 1 cycle from an accepted word to out_valid when the output register is free.
//  - Holding: out_* are stable while out_valid&!out_ready.
//  - States (derived from the occupancy of the output register and the skid register):
//    - EMPTY: neither register occupied.
//    - ONE: output register occupied.
//    - FULL: output and skid registers both occupied.
//  - Transitions:
//    - EMPTY + in xfer -> ONE.
//    - ONE + in xfer without out xfer -> FULL (word goes to skid).
//    - ONE + in xfer with out xfer -> ONE (new word to output).
//    - ONE + out xfer only -> EMPTY.
//    - FULL + out xfer -> ONE (skid moves to output).
//  - in_ready: registered; it equals !FULL.
//  - Simultaneous in+out in ONE: back-to-back throughput of 1 word per cycle, order preserved.
//  - flush: the next state is EMPTY, and both flush and any same-cycle in xfer are discarded.
//    - out_valid=0 and in_ready=1 on the next cycle.
//    - flush has priority over every other event.
//  - Reset mid-operation: outputs return to reset values immediately, without waiting for clk.
//  - Op codes:
//    - R: ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SRA7 SLT8 SLTU9 MUL10 MULH11 MULHSU12 MULHU13
//      DIV14 DIVU15 REM16 REMU17.
//    - I: ADDI18 XORI19 ORI20 ANDI21 SLLI22 SRLI23 SRAI24 SLTI25 SLTIU26.
//    - W: ADDIW29 SLLIW30 SRLIW31 SRAIW32 ADDW33 SUBW34 SLLW35 SRLW36 SRAW37.
//    - M-W: MULW38 DIVW39 DIVUW40 REMW41 REMUW42.
//    - S: SB43 SH44 SW45 SD46. B: BEQ47..BGEU52.
//    - Other: JAL53 JALR54 LUI55 AUIPC56 ECALL57 EBREAK58.
//    - Loads: LB59 LH60 LW61 LBU62 LHU63 LWU64 LD65.
//  - Immediates:
//    - I/load/JALR: sext(inst[31:20]). S: sext({inst[31:25],inst[11:7]}).
//    - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//    - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//    - LUI: sext({inst[31:12],12'b0}), i.e. the final value.
//    - AUIPC: sext(inst[31:12]), unshifted; execute shifts it.
//    - R-type: 0.
//  - Illegal: unknown opcode/funct3/funct7 produces out_op=ILLEGAL_OP, out_illegal=1, out_rd_we=0.
//    - SLLIW/SRLIW/SRAIW with inst[25]=1 are illegal.
//    - The pipeline still advances, and the word is still handshaken.
// STRUCTURE
//  - rv64_decode_pkg holds:
//    - alu_op_e enum with all codes above.
//    - RISC-V opcode localparams.
//    - decoded_t struct {op, rd, rs1, rs2, imm, shamt, pc, rd_we, illegal}.
//  - Sub-module rv64_inst_decoder: purely combinational, maps inst+pc to decoded_t.
//  - The top holds the handshake/skid FSM and two decoded_t registers.
// TESTING
//  1. 0xFFF00093 (ADDI x1,x0,-1) -> op=18 rd=1 rs1=0 imm=0xFFFF_FFFF_FFFF_FFFF rd_we=1.
//  2. 0x43F0D113 (SRAI x2,x1,63) -> op=24 rd=2 rs1=1 shamt=63.
//     0x800002B7 (LUI x5,0x80000) -> op=55 imm=0xFFFF_FFFF_8000_0000.
//  3. 0x022081BB (MULW x3,x1,x2) -> op=38 rs1=1 rs2=2 rd=3.
//     0x00000000 -> op=0xFF illegal=1 rd_we=0.
//  4. Back-to-back words A,B,C with out_ready=0 for 3 cycles:
//     - Expect A in output, B in skid, in_ready=0, C held by fetch.
//     - Release out_ready -> A,B,C emerge in order, 1/cycle, none lost or duplicated.
//  5. FULL state then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     - The next accepted word appears alone.
//  6. rst_n low asynchronously mid-stream -> out_valid=0 and in_ready=1 before next clk edge.
//     - Decoding resumes cleanly after release.

Source files
------------

// File: rtl/rv64_decode_pkg.sv
// Shared definitions for the RV64IM decode stage.
//  - alu_op_e : ALU op codes consumed by the execute stage.
//  - OPC_*    : base RISC-V major opcodes (inst[6:0]).
//  - decoded_t: one decoded instruction bundle.
//  - state_e  : occupancy of the output/skid register pair.
package rv64_decode_pkg;

  localparam int         XLEN       = 64;
  localparam logic [7:0] ILLEGAL_OP = 8'hFF;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [7:0] {
    OP_ADD = 8'd0, OP_SUB = 8'd1, OP_XOR = 8'd2, OP_OR = 8'd3, OP_AND = 8'd4,
    OP_SLL = 8'd5, OP_SRL = 8'd6, OP_SRA = 8'd7, OP_SLT = 8'd8, OP_SLTU = 8'd9,
    OP_MUL = 8'd10, OP_MULH = 8'd11, OP_MULHSU = 8'd12, OP_MULHU = 8'd13,
    OP_DIV = 8'd14, OP_DIVU = 8'd15, OP_REM = 8'd16, OP_REMU = 8'd17,
    OP_ADDI = 8'd18, OP_XORI = 8'd19, OP_ORI = 8'd20, OP_ANDI = 8'd21,
    OP_SLLI = 8'd22, OP_SRLI = 8'd23, OP_SRAI = 8'd24, OP_SLTI = 8'd25, OP_SLTIU = 8'd26,
    OP_ADDIW = 8'd29, OP_SLLIW = 8'd30, OP_SRLIW = 8'd31, OP_SRAIW = 8'd32,
    OP_ADDW = 8'd33, OP_SUBW = 8'd34, OP_SLLW = 8'd35, OP_SRLW = 8'd36, OP_SRAW = 8'd37,
    OP_MULW = 8'd38, OP_DIVW = 8'd39, OP_DIVUW = 8'd40, OP_REMW = 8'd41, OP_REMUW = 8'd42,
    OP_SB = 8'd43, OP_SH = 8'd44, OP_SW = 8'd45, OP_SD = 8'd46,
    OP_BEQ = 8'd47, OP_BNE = 8'd48, OP_BLT = 8'd49, OP_BGE = 8'd50, OP_BLTU = 8'd51, OP_BGEU = 8'd52,
    OP_JAL = 8'd53, OP_JALR = 8'd54, OP_LUI = 8'd55, OP_AUIPC = 8'd56,
    OP_ECALL = 8'd57, OP_EBREAK = 8'd58,
    OP_LB = 8'd59, OP_LH = 8'd60, OP_LW = 8'd61, OP_LBU = 8'd62, OP_LHU = 8'd63,
    OP_LWU = 8'd64, OP_LD = 8'd65,
    OP_ILLEGAL = ILLEGAL_OP
  } alu_op_e;

  typedef struct packed {
    alu_op_e         op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] pc;
    logic            rd_we;
    logic            illegal;
  } decoded_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  // Value presented on the outputs while nothing has been decoded yet.
  function automatic decoded_t idle_bundle();
    decoded_t b;
    b    = '0;
    b.op = OP_ILLEGAL;
    return b;
  endfunction

endpackage

// File: rtl/rv64_decode_stage_decoder.sv
// rv64_inst_decoder: purely combinational RV64IM instruction decoder.
//  inst : raw 32-bit instruction word
//  pc   : PC of inst, passed through
//  dec  : decoded bundle (op, register indices, immediate, shamt, pc, rd_we, illegal)
// Register index fields are always the raw inst fields; the immediate is
// forced to zero for R-type and undecodable words.
module rv64_inst_decoder
  import rv64_decode_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_lui, imm_auipc;
  alu_op_e         op;
  logic [XLEN-1:0] imm;
  logic            no_wb;
  logic            illegal;
  logic            w_form;

  assign opcode    = inst[6:0];
  assign f3        = inst[14:12];
  assign f7        = inst[31:25];
  assign imm_i     = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s     = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b     = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j     = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_lui   = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  // AUIPC immediate stays unshifted; execute applies the << 12.
  assign imm_auipc = {{(XLEN-20){inst[31]}}, inst[31:12]};
  assign w_form    = (opcode == OPC_OP_IMM_32) || (opcode == OPC_OP_32);

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    op    = OP_ILLEGAL;
    imm   = '0;
    no_wb = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (f7)
          7'b0000000: case (f3)
            3'd0: op = OP_ADD;  3'd1: op = OP_SLL; 3'd2: op = OP_SLT; 3'd3: op = OP_SLTU;
            3'd4: op = OP_XOR;  3'd5: op = OP_SRL; 3'd6: op = OP_OR;  default: op = OP_AND;
          endcase
          7'b0100000: if (f3 == 3'd0) op = OP_SUB; else if (f3 == 3'd5) op = OP_SRA;
          7'b0000001: case (f3)
            3'd0: op = OP_MUL; 3'd1: op = OP_MULH; 3'd2: op = OP_MULHSU; 3'd3: op = OP_MULHU;
            3'd4: op = OP_DIV; 3'd5: op = OP_DIVU; 3'd6: op = OP_REM;    default: op = OP_REMU;
          endcase
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        imm = imm_i;
        case (f3)
          3'd0: op = OP_ADDI; 3'd2: op = OP_SLTI; 3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI; 3'd6: op = OP_ORI;  3'd7: op = OP_ANDI;
          // RV64 shifts take a 6-bit shamt, so only inst[31:26] selects the op.
          3'd1: if (inst[31:26] == 6'b000000) op = OP_SLLI;
          default: begin
            if (inst[31:26] == 6'b000000)      op = OP_SRLI;
            else if (inst[31:26] == 6'b010000) op = OP_SRAI;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        imm = imm_i;
        // Full funct7 match: a set inst[25] (shamt >= 32) is illegal for W shifts.
        case (f3)
          3'd0: op = OP_ADDIW;
          3'd1: if (f7 == 7'b0000000) op = OP_SLLIW;
          3'd5: begin
            if (f7 == 7'b0000000)      op = OP_SRLIW;
            else if (f7 == 7'b0100000) op = OP_SRAIW;
          end
          default: ;
        endcase
      end
      OPC_OP_32: begin
        case (f7)
          7'b0000000: case (f3)
            3'd0: op = OP_ADDW; 3'd1: op = OP_SLLW; 3'd5: op = OP_SRLW; default: ;
          endcase
          7'b0100000: if (f3 == 3'd0) op = OP_SUBW; else if (f3 == 3'd5) op = OP_SRAW;
          7'b0000001: case (f3)
            3'd0: op = OP_MULW; 3'd4: op = OP_DIVW; 3'd5: op = OP_DIVUW;
            3'd6: op = OP_REMW; 3'd7: op = OP_REMUW; default: ;
          endcase
          default: ;
        endcase
      end
      OPC_STORE: begin
        imm   = imm_s;
        no_wb = 1'b1;
        case (f3)
          3'd0: op = OP_SB; 3'd1: op = OP_SH; 3'd2: op = OP_SW; 3'd3: op = OP_SD; default: ;
        endcase
      end
      OPC_BRANCH: begin
        imm   = imm_b;
        no_wb = 1'b1;
        case (f3)
          3'd0: op = OP_BEQ; 3'd1: op = OP_BNE;  3'd4: op = OP_BLT;
          3'd5: op = OP_BGE; 3'd6: op = OP_BLTU; 3'd7: op = OP_BGEU; default: ;
        endcase
      end
      OPC_LOAD: begin
        imm = imm_i;
        case (f3)
          3'd0: op = OP_LB;  3'd1: op = OP_LH;  3'd2: op = OP_LW; 3'd3: op = OP_LD;
          3'd4: op = OP_LBU; 3'd5: op = OP_LHU; 3'd6: op = OP_LWU; default: ;
        endcase
      end
      OPC_JAL:   begin op = OP_JAL;   imm = imm_j;     end
      OPC_JALR:  begin imm = imm_i; if (f3 == 3'd0) op = OP_JALR; end
      OPC_LUI:   begin op = OP_LUI;   imm = imm_lui;   end
      OPC_AUIPC: begin op = OP_AUIPC; imm = imm_auipc; end
      OPC_SYSTEM: begin
        imm   = imm_i;
        no_wb = 1'b1;
        if (inst == 32'h0000_0073)      op = OP_ECALL;
        else if (inst == 32'h0010_0073) op = OP_EBREAK;
      end
      default: ;
    endcase
  end

  assign illegal     = (op == OP_ILLEGAL);
  assign dec.op      = op;
  assign dec.rd      = inst[11:7];
  assign dec.rs1     = inst[19:15];
  assign dec.rs2     = inst[24:20];
  assign dec.imm     = illegal ? '0 : imm;
  assign dec.shamt   = w_form ? {{(XLEN-5){1'b0}}, inst[24:20]} : {{(XLEN-6){1'b0}}, inst[25:20]};
  assign dec.pc      = pc;
  assign dec.rd_we   = !illegal && !no_wb && (inst[11:7] != 5'd0);
  assign dec.illegal = illegal;

endmodule

// File: rtl/rv64_decode_stage.sv
// rv64_decode_stage: pipelined RV64IM decode stage with registered output
// and a one-entry skid buffer.
//  clk, rst_n            : clock, asynchronous active-low reset
//  flush                 : drop every held/in-flight word (branch redirect)
//  in_valid/in_ready     : fetch handshake; in_ready is a pure register decode
//  in_inst, in_pc        : instruction word and its PC
//  out_valid/out_ready   : execute handshake
//  out_op..out_illegal   : decoded bundle, stable while stalled
module rv64_decode_stage
  import rv64_decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_shamt,
  output logic [XLEN-1:0] out_pc,
  output logic            out_rd_we,
  output logic            out_illegal
);

  state_e   state_q, state_d;
  decoded_t dec, out_q, skid_q;
  logic     in_xfer, out_xfer;
  logic     load_out_dec, load_out_skid, load_skid;

  rv64_inst_decoder u_decoder (
    .inst (in_inst),
    .pc   (in_pc),
    .dec  (dec)
  );

  // Both handshake outputs decode the state register only, so in_ready never
  // sees out_ready combinationally.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) begin state_d = ST_ONE; load_out_dec = 1'b1; end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            load_out_dec = 1'b1;
          end else if (in_xfer) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (out_xfer) begin state_d = ST_ONE; load_out_skid = 1'b1; end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= idle_bundle();
    end else begin
      state_q <= state_d;
      if (load_out_dec)       out_q <= dec;
      else if (load_out_skid) out_q <= skid_q;
    end
  end

  // NOTE: skid data has no reset; it is only read after being written, and state_q alone marks it occupied.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= dec;
  end

  assign out_op      = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_shamt   = out_q.shamt;
  assign out_pc      = out_q.pc;
  assign out_rd_we   = out_q.rd_we;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv64_decode_stage.sv
// Self-checking bench for rv64_decode_stage: directed decode vectors,
// skid/flush/reset sequences and randomized traffic against a mask/match
// instruction table model with an in-order scoreboard.
module tb_rv64_decode_stage;

  typedef struct packed {
    logic [7:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm, shamt, pc;
    logic        rd_we, illegal;
  } bundle_t;

  typedef enum {F_R, F_I, F_S, F_B, F_J, F_LUI, F_AUIPC, F_SYS} fmt_e;
  typedef struct { logic [31:0] mask, match; logic [7:0] op; fmt_e fmt; } rule_t;
  typedef struct { logic [31:0] inst; bundle_t exp; } vec_t;

  localparam logic [31:0] M_F7 = 32'hFE00707F, M_F6 = 32'hFC00707F;
  localparam logic [31:0] M_F3 = 32'h0000707F, M_OPC = 32'h0000007F, M_ALL = 32'hFFFFFFFF;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_rd_we, out_illegal;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0, out_imm, out_shamt, out_pc;
  logic [7:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  rule_t   rules[$];
  vec_t    vecs[$];
  bundle_t expq[$];
  bundle_t held, idle;
  logic    held_v = 1'b0;
  int      vectors = 0, miscompares = 0;

  rv64_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_shamt(out_shamt), .out_pc(out_pc),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  task automatic rule(input logic [31:0] mask, input logic [31:0] match, input int op, input fmt_e fmt);
    rule_t r;
    r.mask = mask; r.match = match; r.op = 8'(op); r.fmt = fmt;
    rules.push_back(r);
  endtask

  // Reference decode: first matching mask/match rule, immediates by format.
  function automatic bundle_t model(input logic [31:0] w, input logic [63:0] pc);
    bundle_t b;
    int hit = -1;
    foreach (rules[i]) if ((w & rules[i].mask) == rules[i].match) hit = i;
    b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.pc = pc;
    b.shamt = (w[6:0] == 7'h1B || w[6:0] == 7'h3B) ? 64'(w[24:20]) : 64'(w[25:20]);
    if (hit < 0) begin
      b.op = 8'hFF; b.illegal = 1'b1; b.rd_we = 1'b0; b.imm = '0;
    end else begin
      b.op = rules[hit].op; b.illegal = 1'b0;
      case (rules[hit].fmt)
        F_R:     b.imm = '0;
        F_S:     b.imm = 64'($signed({w[31:25], w[11:7]}));
        F_B:     b.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        F_J:     b.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        F_LUI:   b.imm = 64'($signed(w[31:12])) * 64'd4096;
        F_AUIPC: b.imm = 64'($signed(w[31:12]));
        default: b.imm = 64'($signed(w[31:20]));
      endcase
      b.rd_we = !(rules[hit].fmt inside {F_S, F_B, F_SYS}) && (w[11:7] != 5'd0);
    end
    return b;
  endfunction

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.op = out_op; b.rd = out_rd; b.rs1 = out_rs1; b.rs2 = out_rs2; b.imm = out_imm;
    b.shamt = out_shamt; b.pc = out_pc; b.rd_we = out_rd_we; b.illegal = out_illegal;
    return b;
  endfunction

  task automatic addv(input logic [31:0] w, input logic [7:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                      input logic [63:0] shamt, input logic we, input logic ill);
    vec_t v;
    v.inst = w; v.exp.op = op; v.exp.rd = rd; v.exp.rs1 = rs1; v.exp.rs2 = rs2;
    v.exp.imm = imm; v.exp.shamt = shamt; v.exp.rd_we = we; v.exp.illegal = ill;
    v.exp.pc = 64'h1000 + 64'(4 * vecs.size());
    vecs.push_back(v);
  endtask

  // One cycle: drive at negedge, evaluate handshakes 1 time unit later, move to next negedge.
  task automatic drive(input logic v, input logic [31:0] w, input bundle_t e, input logic rdy,
                       input logic fl, output logic acc);
    bundle_t cur;
    in_valid = v; in_inst = w; in_pc = e.pc; out_ready = rdy; flush = fl;
    #1;
    acc = v && in_ready && !fl;
    if (fl) begin
      expq.delete();
      held_v = 1'b0;
    end else begin
      cur = dut_bundle();
      if (held_v) check("hold_stable", {out_valid, cur}, {1'b1, held});
      if (out_valid && rdy) begin
        if (expq.size() == 0) check("spurious_output", {out_valid, cur}, {1'b0, idle});
        else check("out_bundle", cur, expq.pop_front());
      end
      held_v = out_valid && !rdy;
      held   = cur;
      if (acc) expq.push_back(e);
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input bundle_t e, input int rdy_pct);
    logic acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++)
      drive(1'b1, w, e, ($urandom_range(99) < rdy_pct), 1'b0, acc);
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 50 && expq.size() != 0; k++) drive(1'b0, '0, idle, 1'b1, 1'b0, acc);
    check("drain_empty", expq.size(), 0);
  endtask

  initial begin
    logic    acc, pend, have;
    int      cyc;
    logic [31:0] w;
    logic [63:0] pc;
    bundle_t ea, eb, ec;
    rule_t   r;

    idle = '0; idle.op = 8'hFF;

    // R
    rule(M_F7, enc(7'h00, 3'd0, 7'h33), 0, F_R);  rule(M_F7, enc(7'h20, 3'd0, 7'h33), 1, F_R);
    rule(M_F7, enc(7'h00, 3'd4, 7'h33), 2, F_R);  rule(M_F7, enc(7'h00, 3'd6, 7'h33), 3, F_R);
    rule(M_F7, enc(7'h00, 3'd7, 7'h33), 4, F_R);  rule(M_F7, enc(7'h00, 3'd1, 7'h33), 5, F_R);
    rule(M_F7, enc(7'h00, 3'd5, 7'h33), 6, F_R);  rule(M_F7, enc(7'h20, 3'd5, 7'h33), 7, F_R);
    rule(M_F7, enc(7'h00, 3'd2, 7'h33), 8, F_R);  rule(M_F7, enc(7'h00, 3'd3, 7'h33), 9, F_R);
    for (int i = 0; i < 8; i++) rule(M_F7, enc(7'h01, 3'(i), 7'h33), 10 + i, F_R);
    // I
    rule(M_F3, enc(7'h00, 3'd0, 7'h13), 18, F_I); rule(M_F3, enc(7'h00, 3'd4, 7'h13), 19, F_I);
    rule(M_F3, enc(7'h00, 3'd6, 7'h13), 20, F_I); rule(M_F3, enc(7'h00, 3'd7, 7'h13), 21, F_I);
    rule(M_F6, enc(7'h00, 3'd1, 7'h13), 22, F_I); rule(M_F6, enc(7'h00, 3'd5, 7'h13), 23, F_I);
    rule(M_F6, enc(7'h20, 3'd5, 7'h13), 24, F_I); rule(M_F3, enc(7'h00, 3'd2, 7'h13), 25, F_I);
    rule(M_F3, enc(7'h00, 3'd3, 7'h13), 26, F_I);
    // W and M-W
    rule(M_F3, enc(7'h00, 3'd0, 7'h1B), 29, F_I); rule(M_F7, enc(7'h00, 3'd1, 7'h1B), 30, F_I);
    rule(M_F7, enc(7'h00, 3'd5, 7'h1B), 31, F_I); rule(M_F7, enc(7'h20, 3'd5, 7'h1B), 32, F_I);
    rule(M_F7, enc(7'h00, 3'd0, 7'h3B), 33, F_R); rule(M_F7, enc(7'h20, 3'd0, 7'h3B), 34, F_R);
    rule(M_F7, enc(7'h00, 3'd1, 7'h3B), 35, F_R); rule(M_F7, enc(7'h00, 3'd5, 7'h3B), 36, F_R);
    rule(M_F7, enc(7'h20, 3'd5, 7'h3B), 37, F_R); rule(M_F7, enc(7'h01, 3'd0, 7'h3B), 38, F_R);
    rule(M_F7, enc(7'h01, 3'd4, 7'h3B), 39, F_R); rule(M_F7, enc(7'h01, 3'd5, 7'h3B), 40, F_R);
    rule(M_F7, enc(7'h01, 3'd6, 7'h3B), 41, F_R); rule(M_F7, enc(7'h01, 3'd7, 7'h3B), 42, F_R);
    // S, B
    for (int i = 0; i < 4; i++) rule(M_F3, enc(7'h00, 3'(i), 7'h23), 43 + i, F_S);
    rule(M_F3, enc(7'h00, 3'd0, 7'h63), 47, F_B); rule(M_F3, enc(7'h00, 3'd1, 7'h63), 48, F_B);
    for (int i = 4; i < 8; i++) rule(M_F3, enc(7'h00, 3'(i), 7'h63), 45 + i, F_B);
    // Other
    rule(M_OPC, 32'h6F, 53, F_J);   rule(M_F3, enc(7'h00, 3'd0, 7'h67), 54, F_I);
    rule(M_OPC, 32'h37, 55, F_LUI); rule(M_OPC, 32'h17, 56, F_AUIPC);
    rule(M_ALL, 32'h0000_0073, 57, F_SYS); rule(M_ALL, 32'h0010_0073, 58, F_SYS);
    // Loads
    rule(M_F3, enc(7'h00, 3'd0, 7'h03), 59, F_I); rule(M_F3, enc(7'h00, 3'd1, 7'h03), 60, F_I);
    rule(M_F3, enc(7'h00, 3'd2, 7'h03), 61, F_I); rule(M_F3, enc(7'h00, 3'd4, 7'h03), 62, F_I);
    rule(M_F3, enc(7'h00, 3'd5, 7'h03), 63, F_I); rule(M_F3, enc(7'h00, 3'd6, 7'h03), 64, F_I);
    rule(M_F3, enc(7'h00, 3'd3, 7'h03), 65, F_I);

    //   inst          op     rd  rs1 rs2 imm                     shamt we ill
    addv(32'hFFF00093, 8'd18, 1,  0,  31, 64'hFFFF_FFFF_FFFF_FFFF, 63,  1, 0);
    addv(32'h43F0D113, 8'd24, 2,  1,  31, 64'h0000_0000_0000_043F, 63,  1, 0);
    addv(32'h800002B7, 8'd55, 5,  0,  0,  64'hFFFF_FFFF_8000_0000, 0,   1, 0);
    addv(32'h022081BB, 8'd38, 3,  1,  2,  64'h0,                   2,   1, 0);
    addv(32'h00000000, 8'hFF, 0,  0,  0,  64'h0,                   0,   0, 1);
    addv(32'h00000073, 8'd57, 0,  0,  0,  64'h0,                   0,   0, 0);
    addv(32'h0200109B, 8'hFF, 1,  0,  0,  64'h0,                   0,   0, 1);
    addv(32'h0020B423, 8'd46, 8,  1,  2,  64'h8,                   2,   0, 0);
    addv(32'hFFDFF0EF, 8'd53, 1,  31, 29, 64'hFFFF_FFFF_FFFF_FFFC, 61,  1, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {out_valid, in_ready, dut_bundle()}, {1'b0, 1'b1, idle});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode table
    foreach (vecs[i]) begin
      push_word(vecs[i].inst, vecs[i].exp, 100);
      drain();
    end

    // Skid: A, B, C with out_ready low for three cycles, then release
    ea = model(32'h002081B3, 64'h2000);
    eb = model(32'h40208233, 64'h2004);
    ec = model(32'h0020C2B3, 64'h2008);
    drive(1'b1, 32'h002081B3, ea, 1'b0, 1'b0, acc); check("skid_accept_a", acc, 1'b1);
    drive(1'b1, 32'h40208233, eb, 1'b0, 1'b0, acc); check("skid_accept_b", acc, 1'b1);
    drive(1'b1, 32'h0020C2B3, ec, 1'b0, 1'b0, acc);
    check("skid_c_held", {acc, in_ready, out_valid}, {1'b0, 1'b0, 1'b1});
    pend = 1'b1; cyc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(pend, 32'h0020C2B3, ec, 1'b1, 1'b0, acc);
      if (acc) pend = 1'b0;
      cyc++;
      if (!pend && expq.size() == 0) break;
    end
    check("skid_release_cycles", cyc, 3);
    check("skid_all_out", {pend, 32'(expq.size())}, 33'd0);

    // Flush from FULL with a same-cycle input word
    drive(1'b1, 32'h00100093, model(32'h00100093, 64'h3000), 1'b0, 1'b0, acc);
    drive(1'b1, 32'h00200113, model(32'h00200113, 64'h3004), 1'b0, 1'b0, acc);
    #1;
    check("flush_full_before", {out_valid, in_ready}, 2'b10);
    drive(1'b1, 32'h00300193, model(32'h00300193, 64'h3008), 1'b0, 1'b1, acc);
    #1;
    check("flush_after", {out_valid, in_ready}, 2'b01);
    push_word(32'h00400213, model(32'h00400213, 64'h300C), 100);
    drain();

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h00500293, model(32'h00500293, 64'h4000), 1'b0, 1'b0, acc);
    drive(1'b1, 32'h00600313, model(32'h00600313, 64'h4004), 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, in_ready, dut_bundle()}, {1'b0, 1'b1, idle});
    expq.delete(); held_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_word(32'h00700393, model(32'h00700393, 64'h4008), 100);
    push_word(32'h0000A403, model(32'h0000A403, 64'h400C), 50);
    drain();

    // Randomized traffic
    have = 1'b0; w = '0; pc = '0;
    for (int n = 0; n < 800; n++) begin
      if (!have) begin
        if ($urandom_range(99) < 75) begin
          r = rules[$urandom_range(rules.size() - 1)];
          w = r.match | ($urandom & ~r.mask);
        end else begin
          w = $urandom;
        end
        pc = {$urandom, $urandom} & ~64'h3;
        have = 1'b1;
      end
      pend = ($urandom_range(99) < 70);
      drive(pend, w, model(w, pc), ($urandom_range(99) < 65), ($urandom_range(99) < 3), acc);
      if (acc || (pend && flush === 1'b0 && !in_ready === 1'b0 && 1'b0)) have = 1'b0;
      if (acc) have = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
